// File: rtl/const_table_rw_if.sv
// const_table_rw_if: bus bundle for the writable constant table.
//   master : drives write, read-request and reload signals (datapath/firmware side)
//   slave  : the table itself; returns read data, valids, wr_err, busy, parity flags
// Parameters: WORD_SIZE (data width), ADDR_W (address width, log2 of table depth).
interface const_table_rw_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 3
);
  logic                 we;
  logic [ADDR_W-1:0]    waddr;
  logic [WORD_SIZE-1:0] wdata;
  logic                 wr_err;
  logic                 rd_en_a;
  logic [ADDR_W-1:0]    raddr_a;
  logic [WORD_SIZE-1:0] rdata_a;
  logic                 rvalid_a;
  logic                 rd_en_b;
  logic [ADDR_W-1:0]    raddr_b;
  logic [WORD_SIZE-1:0] rdata_b;
  logic                 rvalid_b;
  logic                 reload;
  logic                 busy;
  logic                 rd_perr_a;
  logic                 rd_perr_b;

  modport master (
    output we, waddr, wdata, rd_en_a, raddr_a, rd_en_b, raddr_b, reload,
    input  wr_err, rdata_a, rvalid_a, rdata_b, rvalid_b, busy, rd_perr_a, rd_perr_b
  );

  modport slave (
    input  we, waddr, wdata, rd_en_a, raddr_a, rd_en_b, raddr_b, reload,
    output wr_err, rdata_a, rvalid_a, rdata_b, rvalid_b, busy, rd_perr_a, rd_perr_b
  );
endinterface

// File: rtl/const_table_rw.sv
// const_table_rw: writable constant table feeding the R/C source-operand path.
//   Two registered read ports (A: ALU source, B: address/offset), one write
//   port with per-entry lock, and a reload sweep restoring reset defaults one
//   entry per cycle.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset (table back to defaults, FSM to IDLE)
//   bus    : const_table_rw_if.slave (write, two read ports, reload/busy, parity flags)
// Optional feature: define CONST_TABLE_PARITY_EN to store an even-parity bit per
// entry and flag mismatches on reads; otherwise rd_perr_a/b are tied to 0.
module const_table_rw #(
  parameter int             WORD_SIZE = 16,
  parameter int             DEPTH     = 8,
  parameter logic [DEPTH-1:0] LOCK_MASK = {{(DEPTH-1){1'b0}}, 1'b1}
) (
  input  logic            clk,
  input  logic            rst_n,
  const_table_rw_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    idx;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  // Reset/reload default for entry i, sign-extended to WORD_SIZE.
  function automatic logic signed [WORD_SIZE-1:0] def_val(input int i);
    logic signed [WORD_SIZE-1:0] v;
    case (i)
      1:       v = WORD_SIZE'(1);
      2:       v = WORD_SIZE'(2);
      3:       v = WORD_SIZE'(4);
      4:       v = WORD_SIZE'(8);
      5:       v = WORD_SIZE'(32);
      6:       v = WORD_SIZE'(48);
      7:       v = {WORD_SIZE{1'b1}};
      default: v = '0;
    endcase
    return v;
  endfunction

  logic sweep;
  logic wr_ok;
  logic rd_acc_a, rd_acc_b;
  logic byp_a, byp_b;
  logic [WORD_SIZE-1:0] rd_word_a, rd_word_b;

  assign sweep = (state == SWEEP);
  // A reload request in IDLE takes priority over a same-cycle write.
  assign wr_ok    = bus.we & ~sweep & ~bus.reload & ~LOCK_MASK[bus.waddr];
  assign rd_acc_a = bus.rd_en_a & ~sweep;
  assign rd_acc_b = bus.rd_en_b & ~sweep;
  // Write-through: a read hitting the address being written sees the new data.
  assign byp_a     = wr_ok & (bus.waddr == bus.raddr_a);
  assign byp_b     = wr_ok & (bus.waddr == bus.raddr_b);
  assign rd_word_a = byp_a ? bus.wdata : mem[bus.raddr_a];
  assign rd_word_b = byp_b ? bus.wdata : mem[bus.raddr_b];

  // Stage p0 -> p1: control FSM and registered read outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      bus.busy     <= 1'b0;
      bus.wr_err   <= 1'b0;
      bus.rvalid_a <= 1'b0;
      bus.rvalid_b <= 1'b0;
      bus.rdata_a  <= '0;
      bus.rdata_b  <= '0;
    end else begin
      bus.wr_err   <= bus.we & ~wr_ok;
      bus.rvalid_a <= rd_acc_a;
      bus.rvalid_b <= rd_acc_b;
      if (rd_acc_a) bus.rdata_a <= rd_word_a;
      if (rd_acc_b) bus.rdata_b <= rd_word_b;
      case (state)
        IDLE: begin
          if (bus.reload) begin
            state    <= SWEEP;
            idx      <= '0;
            bus.busy <= 1'b1;
          end
        end
        SWEEP: begin
          idx <= idx + 1'b1;
          // Leaving on the last index keeps idx from starting a second pass.
          if (idx == LAST_IDX) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONST_TABLE_PARITY_EN
  logic [DEPTH-1:0] par_mem;
  logic perr_a_p1, perr_b_p1;
`endif

  // Table storage: reset defaults, sweep rewrite (ignores locks), or host write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= def_val(i);
`ifdef CONST_TABLE_PARITY_EN
        par_mem[i] <= ^def_val(i);
`endif
      end
    end else if (sweep) begin
      mem[idx] <= def_val(int'(idx));
`ifdef CONST_TABLE_PARITY_EN
      par_mem[idx] <= ^def_val(int'(idx));
`endif
    end else if (wr_ok) begin
      mem[bus.waddr] <= bus.wdata;
`ifdef CONST_TABLE_PARITY_EN
      par_mem[bus.waddr] <= ^bus.wdata;
`endif
    end
  end

`ifdef CONST_TABLE_PARITY_EN
  // Stage p0 -> p1: parity recheck, flagged together with rvalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perr_a_p1 <= 1'b0;
      perr_b_p1 <= 1'b0;
    end else begin
      perr_a_p1 <= rd_acc_a & ~byp_a & ((^mem[bus.raddr_a]) ^ par_mem[bus.raddr_a]);
      perr_b_p1 <= rd_acc_b & ~byp_b & ((^mem[bus.raddr_b]) ^ par_mem[bus.raddr_b]);
    end
  end
  assign bus.rd_perr_a = perr_a_p1;
  assign bus.rd_perr_b = perr_b_p1;
`else
  assign bus.rd_perr_a = 1'b0;
  assign bus.rd_perr_b = 1'b0;
`endif
endmodule

// File: doc/const_table_rw.md
Name: const_table_rw

Overview:
- Parametrised, writable successor to the fixed CPU constant table; supplies constant operands for the R/C source-operand path of the multi-cycle datapath.
- Two registered read ports (A: ALU source, B: address/offset path).
- One write port so firmware/debug can override table entries.
- Locked entries are read-only; a reload sequencer restores reset defaults one entry per cycle.

Parameters:
- WORD_SIZE, 16, data width in bits.
- DEPTH, 8, number of entries; power of two, minimum 8.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- LOCK_MASK, 8'h01 zero-extended to DEPTH, bit i=1 makes entry i read-only (entry 0 locked by default).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- we  in  1  write request
- waddr  in  ADDR_W  write address
- wdata  in  WORD_SIZE  write data
- wr_err  out  1  one-cycle pulse when a write is rejected
- rd_en_a  in  1  read request, port A
- raddr_a  in  ADDR_W  read address, port A
- rdata_a  out  WORD_SIZE  read data, port A
- rvalid_a  out  1  port A data valid, one-cycle pulse
- rd_en_b  in  1  read request, port B
- raddr_b  in  ADDR_W  read address, port B
- rdata_b  out  WORD_SIZE  read data, port B
- rvalid_b  out  1  port B data valid, one-cycle pulse
- reload  in  1  start restoring defaults
- busy  out  1  reload sweep in progress
- rd_perr_a  out  1  parity error on port A (optional feature)
- rd_perr_b  out  1  parity error on port B (optional feature)

Behaviour:
- Defaults for entries 0..7 are 0, 1, 2, 4, 8, 32, 48, -1. Each default is sign-extended to WORD_SIZE, so -1 is all ones. Entries 8..DEPTH-1 default to 0.
- Reset (rst_n=0 at a clk edge):
  - All entries load their defaults in one cycle.
  - rdata_a/b are 0; rvalid_a/b, wr_err, busy and rd_perr_a/b are 0.
  - The FSM goes to IDLE.
  - Reset mid-reload aborts the sweep; the table still ends at full defaults.
- Read:
  - rd_en_x sampled high at edge N gives rdata_x = entry[raddr_x] and rvalid_x=1 after edge N+1 (latency 1).
  - rdata_x holds its last value until the next accepted read; rvalid_x is high for exactly one cycle per accepted read.
  - Reads are ignored while busy=1: no rvalid, rdata holds.
  - Both ports may read any addresses in the same cycle, including the same address.
- Write:
  - we=1, waddr unlocked and busy=0: the entry updates at the edge.
  - Write-through bypass: a read of the same address in the same cycle returns the new wdata.
  - Rejected write (waddr locked, or busy=1): no update; wr_err pulses 1 the next cycle.
- Reload FSM, states IDLE and SWEEP:
  - IDLE to SWEEP when reload=1. An idx counter clears to 0 and busy=1 from the next cycle.
  - SWEEP writes default[idx] into entry[idx] each cycle and increments idx.
  - SWEEP returns to IDLE after idx=DEPTH-1 is written. busy=1 for exactly DEPTH cycles.
  - Locked entries are also rewritten during the sweep.
  - reload asserted during SWEEP is ignored; no restart.
  - idx is ADDR_W wide; it must not wrap into a second pass.
- Simultaneous reload and we in IDLE: reload wins, the write is rejected and wr_err pulses.
- Address arithmetic is unsigned; all addresses are valid because DEPTH is 2^ADDR_W.

Optional Feature:
- CONST_TABLE_PARITY_EN defined:
  - Each entry stores an extra even-parity bit, computed on reset, write and reload.
  - On each accepted read, rd_perr_x registers the parity recheck alongside rvalid_x; it is 1 on mismatch, otherwise 0.
- Not defined: no parity storage; rd_perr_a/b are tied to 0.
- The port list is identical in both cases.

Test Plan:
- Reset then read A addresses 0..7 one per cycle -> rdata_a = 0000, 0001, 0002, 0004, 0008, 0020, 0030, FFFF, each one cycle after rd_en_a, with an rvalid_a pulse each time.
- Write addr 3 = 1234, then read A=3 and B=3 in the same cycle -> both return 1234 next cycle. Then write addr 0 = 5555 -> wr_err pulses; a read of 0 returns 0000.
- Same cycle: we to addr 5 = BEEF and rd_en_a at addr 5 -> rdata_a = BEEF one cycle later (bypass).
- Write addr 6 = 0BAD, pulse reload, issue reads and writes during busy -> busy high exactly 8 cycles, no rvalid, wr_err on each write; afterwards a read of 6 returns 0030.
- Assert rst_n=0 for one cycle at sweep idx=3 after modifying entry 7 -> busy=0 next cycle; entry 7 reads FFFF.
- With CONST_TABLE_PARITY_EN and a forced stored-bit flip on entry 2 -> reading 2 gives rd_perr_a=1; an unflipped entry gives 0. Without the macro, rd_perr stays 0.
